// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and the bit-period helper.
// Used by both uart_tx and uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } uart_state_e;

   localparam logic [7:0] PAR_NONE = "L";
   localparam logic [7:0] PAR_EVEN = "M";
   localparam logic [7:0] PAR_ODD  = "N";

   // Clocks per bit, truncated; callers rely on the result being at least 8.
   function automatic int calc_clkdiv(input int clk_rate, input int baud_rate);
      return clk_rate / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
// Every flop resets to the idle-high line level so reset never fakes a start edge.
module uart_rx_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic rx_sync_o,
   output logic rx_fall_o
);

   logic meta_q;
   logic prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q    <= 1'b1;
         rx_sync_o <= 1'b1;
         prev_q    <= 1'b1;
      end else begin
         meta_q    <= rx_i;
         rx_sync_o <= meta_q;
         prev_q    <= rx_sync_o;
      end
   end

   assign rx_fall_o = prev_q & ~rx_sync_o;

endmodule

// File: rtl/uart_rx.sv
// Multi-word UART receiver: oversampled start/data/parity/stop checking, WORD_COUNT words per frame.
// Build option UART_RX_MAJORITY_EN selects 2-of-3 majority voting around each mid-bit sample.
module uart_rx
   import uart_pkg::*;
#(
   parameter int         CLK_RATE   = 10000000,
   parameter int         BAUD_RATE  = 115200,
   parameter int         WORD_LEN   = 8,
   parameter int         WORD_COUNT = 1,
   parameter logic [7:0] PARITY     = PAR_NONE,
   parameter int         STOP       = 1,
   parameter int         GAP_BITS   = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           rx_i,
   output logic [WORD_COUNT*WORD_LEN-1:0] rx_data_o,
   output logic                           rx_valid_o,
   output logic                           rx_busy_o,
   output logic                           rx_parity_err_o,
   output logic                           rx_frame_err_o,
   output logic [2:0]                     rx_state_o
);

   localparam int CLKDIV  = calc_clkdiv(CLK_RATE, BAUD_RATE);
   localparam int FW      = WORD_COUNT * WORD_LEN;
   localparam int CW      = $clog2(CLKDIV) + 1;
   localparam int GAP_CYC = GAP_BITS * CLKDIV;
   localparam int GW      = $clog2(GAP_CYC) + 1;

   localparam logic [CW-1:0] HALF_END = CW'(CLKDIV / 2);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKDIV - 1);
   localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYC - 1);
   localparam logic [3:0]    DATA_END = 4'(WORD_LEN - 1);
   localparam logic [3:0]    STOP_END = 4'(STOP - 1);
   localparam logic [7:0]    WC_END   = 8'(WORD_COUNT);

   logic                rx_s;
   logic                rx_fall;
   uart_state_e         state;
   logic [CW-1:0]       cnt;
   logic [3:0]          bit_cnt;
   logic [GW-1:0]       gap_cnt;
   logic [WORD_LEN-1:0] word;
   logic [FW-1:0]       asm_q;
   logic [7:0]          wcnt;
   logic                par_flag;

   logic                bit_tick;
   logic                bit_val;
   logic                par_exp;
   logic [FW-1:0]       asm_next;

   uart_rx_sync u_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rx_i      (rx_i),
      .rx_sync_o (rx_s),
      .rx_fall_o (rx_fall)
   );

   // Bit decisions happen one cycle after mid-bit in both builds, so the
   // majority vote can see mid-1, mid and mid+1 without shifting rx_valid_o.
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;
   assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
   logic       hist;
   assign bit_val = hist;
`endif

   always_comb begin
      bit_tick = (state == S_START) ? (cnt == HALF_END) : (cnt == BIT_END);
      par_exp  = (PARITY == PAR_ODD) ? ~^word : ^word;
      asm_next = (asm_q << WORD_LEN) | FW'(word);
   end

   assign rx_state_o = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         cnt             <= '0;
         bit_cnt         <= '0;
         gap_cnt         <= '0;
         word            <= '0;
         asm_q           <= '0;
         wcnt            <= '0;
         par_flag        <= 1'b0;
         hist            <= '1;
         rx_data_o       <= '0;
         rx_valid_o      <= 1'b0;
         rx_busy_o       <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
      end else begin
`ifdef UART_RX_MAJORITY_EN
         hist <= {hist[0], rx_s};
`else
         hist <= rx_s;
`endif
         rx_valid_o     <= 1'b0;
         rx_frame_err_o <= 1'b0;

         case (state)
            S_IDLE: begin
               // Gap timeout is evaluated before the edge so a coincident edge starts word 0.
               if (wcnt != 8'd0 && rx_s) begin
                  if (gap_cnt == GAP_END) begin
                     gap_cnt   <= '0;
                     wcnt      <= '0;
                     par_flag  <= 1'b0;
                     asm_q     <= '0;
                     rx_busy_o <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end else begin
                  gap_cnt <= '0;
               end
               if (rx_fall) begin
                  state   <= S_START;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end

            S_START: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (!bit_val) begin
                     state     <= S_DATA;
                     rx_busy_o <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (bit_tick) begin
                  cnt  <= '0;
                  word <= {bit_val, word[WORD_LEN-1:1]};
                  if (bit_cnt == DATA_END) begin
                     bit_cnt <= '0;
                     state   <= (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_PARITY: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  state <= S_STOP;
                  if (bit_val != par_exp) par_flag <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (!bit_val) begin
                     rx_frame_err_o <= 1'b1;
                     wcnt           <= '0;
                     par_flag       <= 1'b0;
                     asm_q          <= '0;
                     rx_busy_o      <= 1'b0;
                     bit_cnt        <= '0;
                     state          <= S_IDLE;
                  end else if (bit_cnt == STOP_END) begin
                     bit_cnt <= '0;
                     state   <= S_IDLE;
                     if (wcnt + 8'd1 == WC_END) begin
                        rx_data_o       <= asm_next;
                        rx_valid_o      <= 1'b1;
                        rx_parity_err_o <= par_flag;
                        wcnt            <= '0;
                        par_flag        <= 1'b0;
                        asm_q           <= '0;
                        rx_busy_o       <= 1'b0;
                     end else begin
                        asm_q <= asm_next;
                        wcnt  <= wcnt + 8'd1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
